// File: rtl/ysyx_25020037_cache_pkg.sv
// Shared definitions for the associative instruction cache: controller
// state encoding and helpers that derive address-field widths from the
// cache geometry parameters.
package ysyx_25020037_cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REFILL = 3'd2,
        RESP   = 3'd3,
        FLUSH  = 3'd4
    } state_e;

    // Byte-offset width inside one instruction word.
    function automatic int boff_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Word-offset width inside one cache line.
    function automatic int woff_width(input int line_words);
        return $clog2(line_words);
    endfunction

    // Set-index width.
    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever address bits remain above the set index.
    function automatic int tag_width(input int addr_width, input int data_width,
                                     input int sets, input int line_words);
        return addr_width - boff_width(data_width) - woff_width(line_words) - idx_width(sets);
    endfunction

    // Round-robin pointer width; a direct-mapped cache still keeps a 1-bit pointer.
    function automatic int ptr_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/ysyx_25020037_icache_way.sv
// One way of the instruction cache: valid bits, tag array and line data,
// with a combinational tag compare against the addressed set.
module ysyx_25020037_icache_way
    import ysyx_25020037_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_all,
    input  logic [$clog2(SETS)-1:0]       idx,
    input  logic [TAG_W-1:0]              tag,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_woff,
    output logic                          hit,
    output logic                          valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          wr_en,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_woff,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          tag_we
);

    logic [SETS-1:0]       valid_q;
    logic [SETS-1:0]       valid_d;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS*LINE_WORDS];

    assign valid   = valid_q[idx];
    assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
    assign rd_data = data_mem[{idx, rd_woff}];

    // Valid bits: a flush clears every set, a completed refill marks its set.
    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (tag_we) begin
            valid_d[idx] = 1'b1;
        end
    end

    // Valid register, the only state in a way that needs resetting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays stay unreset because the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[idx] <= tag;
        end
        if (wr_en) begin
            data_mem[{idx, wr_woff}] <= wr_data;
        end
    end

endmodule

// File: rtl/ysyx_25020037_icache_assoc.sv
// Blocking set-associative instruction cache with line refill, victim
// selection (first invalid way, else per-set round-robin), whole-cache
// flush for fence.i, and saturating hit/miss counters.
module ysyx_25020037_icache_assoc
    import ysyx_25020037_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_hit,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int BOFF_W = boff_width(DATA_WIDTH);
    localparam int WOFF_W = woff_width(LINE_WORDS);
    localparam int IDX_W  = idx_width(SETS);
    localparam int TAG_W  = tag_width(ADDR_WIDTH, DATA_WIDTH, SETS, LINE_WORDS);
    localparam int PTR_W  = ptr_width(WAYS);
    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(LINE_WORDS - 1);

    state_e                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [WOFF_W-1:0]     beat_cnt_q,   beat_cnt_d;
    logic [PTR_W-1:0]      victim_q,     victim_d;
    logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
    logic                  resp_hit_q,   resp_hit_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [31:0]           hit_cnt_q,    hit_cnt_d;
    logic [31:0]           miss_cnt_q,   miss_cnt_d;
    logic [PTR_W-1:0]      rr_q [SETS];
    logic [PTR_W-1:0]      rr_d [SETS];

    logic [WOFF_W-1:0]     woff;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WAYS-1:0]       hit_vec;
    logic [WAYS-1:0]       valid_vec;
    logic [DATA_WIDTH-1:0] way_data [WAYS];
    logic [DATA_WIDTH-1:0] hit_data;
    logic [PTR_W-1:0]      victim;
    logic                  fill_we;
    logic                  fill_tag_we;
    logic                  clear_all;
    logic                  unused_byte_bits;

    assign woff = addr_q[BOFF_W +: WOFF_W];
    assign idx  = addr_q[BOFF_W + WOFF_W +: IDX_W];
    assign tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign unused_byte_bits = ^addr_q[BOFF_W-1:0];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        ysyx_25020037_icache_way #(
            .DATA_WIDTH (DATA_WIDTH),
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .clear_all (clear_all),
            .idx       (idx),
            .tag       (tag),
            .rd_woff   (woff),
            .hit       (hit_vec[g]),
            .valid     (valid_vec[g]),
            .rd_data   (way_data[g]),
            .wr_en     (fill_we && (victim_q == PTR_W'(g))),
            .wr_woff   (beat_cnt_q),
            .wr_data   (mem_data),
            .tag_we    (fill_tag_we && (victim_q == PTR_W'(g)))
        );
    end

    // Hit-word mux and victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        hit_data = '0;
        victim   = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_data = hit_data | way_data[w];
            end
            if (!valid_vec[w]) begin
                victim = PTR_W'(w);
            end
        end
    end

    // Controller next state: lookup, refill beat handling, flush and counters.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_cnt_d   = beat_cnt_q;
        victim_d     = victim_q;
        resp_data_d  = resp_data_q;
        resp_hit_d   = resp_hit_q;
        flush_pend_d = flush_pend_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        rr_d         = rr_q;
        fill_we      = 1'b0;
        fill_tag_we  = 1'b0;
        clear_all    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d = FLUSH;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (|hit_vec) begin
                    resp_data_d = hit_data;
                    resp_hit_d  = 1'b1;
                    hit_cnt_d   = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
                    state_d     = RESP;
                end else begin
                    victim_d    = victim;
                    resp_hit_d  = 1'b0;
                    beat_cnt_d  = '0;
                    miss_cnt_d  = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    fill_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + WOFF_W'(1);
                    if (beat_cnt_q == woff) begin
                        resp_data_d = mem_data;
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        fill_tag_we = 1'b1;
                        rr_d[idx]   = (rr_q[idx] == PTR_W'(WAYS - 1)) ? '0 : rr_q[idx] + PTR_W'(1);
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            FLUSH: begin
                clear_all    = 1'b1;
                flush_pend_d = 1'b0;
                for (int s = 0; s < SETS; s++) begin
                    rr_d[s] = '0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush && (state_q == LOOKUP || state_q == REFILL || state_q == RESP)) begin
            flush_pend_d = 1'b1;
        end
    end

    // Controller registers with asynchronous reset back to an empty, idle cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beat_cnt_q   <= '0;
            victim_q     <= '0;
            resp_data_q  <= '0;
            resp_hit_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_cnt_q   <= beat_cnt_d;
            victim_q     <= victim_d;
            resp_data_q  <= resp_data_d;
            resp_hit_q   <= resp_hit_d;
            flush_pend_q <= flush_pend_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            rr_q         <= rr_d;
        end
    end

    assign cpu_ready  = (state_q == RESP);
    assign cpu_hit    = (state_q == RESP) && resp_hit_q;
    assign cpu_data   = resp_data_q;
    assign flush_done = (state_q == FLUSH);
    assign mem_req    = (state_q == REFILL);
    assign mem_addr   = (state_q == REFILL) ?
                        {addr_q[ADDR_WIDTH-1:BOFF_W+WOFF_W], {(BOFF_W+WOFF_W){1'b0}}} : '0;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_25020037_icache_assoc.sv
// Directed bench for the associative instruction cache: cold miss, hit,
// set conflict eviction, flush priority, deferred flush, stray beats and
// reset in the middle of a refill.
module tb_ysyx_25020037_icache_assoc;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ready;
    logic [31:0] cpu_data;
    logic        cpu_hit;
    logic        flush;
    logic        flush_done;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    ysyx_25020037_icache_assoc #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .WAYS       (2),
        .SETS       (16),
        .LINE_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_data   (cpu_data),
        .cpu_hit    (cpu_hit),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing-store contents: line base bits [23:0] shifted up, plus 0x11*(beat+1).
    function automatic logic [31:0] beatValue(input logic [31:0] base, input int k);
        return {base[23:0], 8'h00} | (32'(k + 1) * 32'h11);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One fetch with a responding memory; optional flush at start, flush
    // during refill, or reset after a given number of delivered beats.
    task automatic applyStimulus(input logic [31:0] addr, input bit with_flush,
                                 input bit flush_mid, input int rst_after,
                                 output logic [31:0] data, output logic hit,
                                 output int lat, output logic [31:0] maddr,
                                 output bit used_mem, output int flush_cyc,
                                 output logic req_after_rst, output bit timeout);
        int beat;
        bit flush_sent;
        beat = 0;
        flush_sent = 0;
        lat = 0;
        data = '0;
        hit = 1'b0;
        maddr = '0;
        used_mem = 0;
        flush_cyc = 0;
        req_after_rst = 1'b1;
        timeout = 1;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        flush    = with_flush;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            mem_valid = 1'b0;
            flush     = 1'b0;
            if (flush_done && flush_cyc == 0) flush_cyc = cyc;
            if (cpu_ready) begin
                data    = cpu_data;
                hit     = cpu_hit;
                lat     = cyc;
                timeout = 0;
                break;
            end
            if (rst_after > 0 && beat == rst_after && mem_req) begin
                rst = 1'b1;
                #1;
                req_after_rst = mem_req;
                timeout = 0;
                break;
            end
            if (mem_req) begin
                if (flush_mid && !flush_sent) begin
                    flush = 1'b1;
                    flush_sent = 1;
                end
                used_mem  = 1;
                maddr     = mem_addr;
                mem_valid = 1'b1;
                mem_data  = beatValue(mem_addr, beat);
                beat++;
            end
        end
        cpu_req   = 1'b0;
        mem_valid = 1'b0;
        flush     = 1'b0;
    endtask

    logic [31:0] d;
    logic        h;
    int          lat;
    logic [31:0] ma;
    bit          um;
    int          fc;
    logic        rq;
    bit          to;
    bit          seen;

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = '0;
        flush = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
        checkOutput("rst_cpu_data", cpu_data, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_hit_cnt", hit_cnt, 32'd0);
        checkOutput("rst_miss_cnt", miss_cnt, 32'd0);
        rst = 1'b0;

        // Cold miss.
        applyStimulus(32'h8000_0004, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("cold_timeout", 32'(to), 32'd0);
        checkOutput("cold_mem_addr", ma, 32'h8000_0000);
        checkOutput("cold_data", d, 32'h22);
        checkOutput("cold_hit", 32'(h), 32'd0);
        checkOutput("cold_latency", 32'(lat), 32'd6);
        checkOutput("cold_miss_cnt", miss_cnt, 32'd1);

        // Re-fetch from the same line.
        applyStimulus(32'h8000_000C, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("hit_latency", 32'(lat), 32'd2);
        checkOutput("hit_flag", 32'(h), 32'd1);
        checkOutput("hit_data", d, 32'h44);
        checkOutput("hit_no_mem", 32'(um), 32'd0);
        checkOutput("hit_cnt_1", hit_cnt, 32'd1);

        // Conflict in set 0: third line evicts way 0.
        applyStimulus(32'h8000_0100, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("fill100_data", d, 32'h0001_0011);
        checkOutput("fill100_hit", 32'(h), 32'd0);
        applyStimulus(32'h8000_0200, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("fill200_mem_addr", ma, 32'h8000_0200);
        checkOutput("fill200_data", d, 32'h0002_0011);
        applyStimulus(32'h8000_0100, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("re100_hit", 32'(h), 32'd1);
        checkOutput("re100_data", d, 32'h0001_0011);
        applyStimulus(32'h8000_0000, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("re000_hit", 32'(h), 32'd0);
        checkOutput("re000_used_mem", 32'(um), 32'd1);
        applyStimulus(32'h8000_0208, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("re208_hit", 32'(h), 32'd1);
        checkOutput("re208_data", d, 32'h0002_0033);
        checkOutput("conflict_hit_cnt", hit_cnt, 32'd3);
        checkOutput("conflict_miss_cnt", miss_cnt, 32'd4);

        // Flush and request together: flush wins, then the request misses.
        applyStimulus(32'h8000_0208, 1, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("flushreq_done_cyc", 32'(fc), 32'd1);
        checkOutput("flushreq_hit", 32'(h), 32'd0);
        checkOutput("flushreq_latency", 32'(lat), 32'd8);
        checkOutput("flushreq_data", d, 32'h0002_0033);

        // Stray beats while idle must not disturb the cache.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        mem_valid = 1'b0;
        applyStimulus(32'h8000_020C, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("stray_hit", 32'(h), 32'd1);
        checkOutput("stray_data", d, 32'h0002_0044);

        // Flush arriving mid-refill is deferred until the controller is idle.
        applyStimulus(32'h8000_0300, 0, 1, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("defer_data", d, 32'h0003_0011);
        checkOutput("defer_early_done", 32'(fc), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (flush_done) seen = 1;
        end
        checkOutput("defer_flush_done", 32'(seen), 32'd1);
        applyStimulus(32'h8000_020C, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("after_flush_hit", 32'(h), 32'd0);
        checkOutput("after_flush_latency", 32'(lat), 32'd6);
        checkOutput("pre_rst_miss_cnt", miss_cnt, 32'd7);
        checkOutput("pre_rst_hit_cnt", hit_cnt, 32'd4);

        // Reset after the second beat of a refill.
        applyStimulus(32'h8000_0400, 0, 0, 2, d, h, lat, ma, um, fc, rq, to);
        checkOutput("rst_mid_timeout", 32'(to), 32'd0);
        checkOutput("rst_mid_mem_req", 32'(rq), 32'd0);
        checkOutput("rst_mid_hit_cnt", hit_cnt, 32'd0);
        checkOutput("rst_mid_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h8000_0404, 0, 0, 0, d, h, lat, ma, um, fc, rq, to);
        checkOutput("post_rst_hit", 32'(h), 32'd0);
        checkOutput("post_rst_mem_addr", ma, 32'h8000_0400);
        checkOutput("post_rst_data", d, 32'h0004_0022);
        checkOutput("post_rst_miss_cnt", miss_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25020037_icache_assoc.md
YSYX_25020037_ICACHE_ASSOC -- requirements
Module: ysyx_25020037_icache_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, instruction word width.
REQ-003 SHALL have parameter WAYS, 2, associativity; legal values 1, 2, 4.
REQ-004 SHALL have parameter SETS, 16, sets per way; power of 2.
REQ-005 SHALL have parameter LINE_WORDS, 4, words per line; power of 2 and at least 2.
REQ-006 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have ports cpu_req, input, 1, fetch request, and cpu_addr, input, ADDR_WIDTH, word-aligned byte address.
REQ-009 SHALL have ports cpu_ready, output, 1, one-cycle data-valid pulse, and cpu_data, output, DATA_WIDTH, fetched word.
REQ-010 SHALL have port cpu_hit, output, 1, asserted together with cpu_ready when the request hit.
REQ-011 SHALL have ports flush, input, 1, invalidate-all request (fence.i), and flush_done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have ports mem_req, output, 1, refill request, and mem_addr, output, ADDR_WIDTH, line-aligned refill base address.
REQ-013 SHALL have ports mem_valid, input, 1, beat valid, and mem_data, input, DATA_WIDTH, beat data; beats arrive in ascending word order.
REQ-014 SHALL have ports hit_cnt and miss_cnt, output, 32, saturating performance counters.

Function
REQ-015 SHALL split the address, low to high, into byte offset log2(DATA_WIDTH/8), word offset log2(LINE_WORDS), set index log2(SETS), and tag (the remainder).
REQ-016 SHALL implement FSM states IDLE, LOOKUP, REFILL, RESP and FLUSH.
REQ-017 SHALL, in IDLE with cpu_req=1 and flush=0, capture cpu_addr and go to LOOKUP; the requester holds cpu_req until cpu_ready.
REQ-018 SHALL, in LOOKUP, compare the captured tag against all valid ways of the set in parallel.
REQ-019 SHALL, on a hit, pulse cpu_ready and cpu_hit with the word on the cycle after LOOKUP (request edge + 2) and return to IDLE.
REQ-020 SHALL, on a miss, assert mem_req with mem_addr equal to the captured address with word and byte offsets zeroed, starting on the cycle after LOOKUP.
REQ-021 SHALL hold mem_req and mem_addr stable through REFILL and count beats on mem_valid with a log2(LINE_WORDS)-bit counter.
REQ-022 SHALL, on the beat where count equals LINE_WORDS-1, deassert mem_req on the next edge, write the full line, tag and valid bit, and go to RESP.
REQ-023 SHALL, in RESP, pulse cpu_ready with cpu_hit=0 and cpu_data equal to the beat whose index equals the captured word offset, then return to IDLE.
REQ-024 SHALL choose as victim the lowest-numbered invalid way; if none is invalid, it SHALL use the per-set round-robin pointer, which advances modulo WAYS on each refill of that set.
REQ-025 SHALL, when flush=1 in IDLE, enter FLUSH, clear all valid bits and round-robin pointers in one cycle, pulse flush_done, and return to IDLE.
REQ-026 SHALL, when flush and cpu_req are both high in IDLE, give flush priority; the held request is served afterwards and misses.
REQ-027 SHALL latch a flush that arrives outside IDLE and perform it when the FSM next enters IDLE.
REQ-028 SHALL ignore mem_valid outside REFILL.
REQ-029 SHALL hold cpu_ready, cpu_hit, flush_done and mem_req low in all cycles other than those stated above.
REQ-030 SHALL increment hit_cnt per hit and miss_cnt per miss, each saturating at 0xFFFFFFFF.

Reset
REQ-031 SHALL, on rst, force state IDLE, all valid bits 0, pointers 0, the beat counter 0, both counters 0, and all outputs 0.
REQ-032 SHALL, on rst asserted mid-REFILL, drop mem_req immediately, discard the partial line, and clear the pending-flush latch.
REQ-033 SHALL leave tag and data arrays uninitialised, because valid bits gate their use.

Structure
REQ-034 SHALL place the FSM state encoding and the derived widths (offset, index and tag widths) in package ysyx_25020037_cache_pkg.
REQ-035 SHALL use one sub-module, ysyx_25020037_icache_way, instantiated WAYS times, holding the tag, valid and data arrays with a combinational hit output.

Verification
REQ-036 Cold miss: request 0x80000004, beats 0x11,0x22,0x33,0x44 -> mem_addr=0x80000000, cpu_data=0x22, cpu_hit=0, miss_cnt=1.
REQ-037 Re-fetch 0x8000000C -> cpu_ready at request edge + 2, cpu_hit=1, cpu_data=0x44, hit_cnt=1, mem_req stays 0.
REQ-038 Conflict (WAYS=2, SETS=16): fill 0x80000000, 0x80000100, 0x80000200 -> the third fill evicts way 0; re-fetching 0x80000100 hits and 0x80000000 misses.
REQ-039 Flush and cpu_req high together in IDLE -> flush_done pulses first, then the request misses and refills.
REQ-040 rst asserted after the 2nd beat of a refill -> mem_req drops immediately; the next fetch of the same line misses.
